// File: rtl/q2_lcd_ctrl.sv
// q2 bus display/keypad controller: turns CPU writes at IO_ADDR into
// HD44780-style LCD transactions and answers CPU reads with the keypad word.
module q2_lcd_ctrl #(
    parameter logic [11:0] IO_ADDR    = 12'hFFF,
    parameter int          FIFO_DEPTH = 8,
    parameter int          INIT_WAIT  = 1500000,
    parameter int          E_CYCLES   = 25,
    parameter int          CMD_WAIT   = 2000,
    parameter int          CLEAR_WAIT = 80000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] abus,
    input  logic [11:0] dbus_in,
    input  logic        wrm,
    input  logic        rdm,
    input  logic [11:0] keys_n,
    output logic [11:0] dbus_out,
    output logic        dbus_oe,
    output logic        lcd_rs,
    output logic        lcd_e,
    output logic [7:0]  lcd_data,
    output logic        busy,
    output logic        overflow
);

    localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW     = AW + 1;
    localparam int MAX_A    = (INIT_WAIT > E_CYCLES) ? INIT_WAIT : E_CYCLES;
    localparam int MAX_B    = (CMD_WAIT > CLEAR_WAIT) ? CMD_WAIT : CLEAR_WAIT;
    localparam int MAX_WAIT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW       = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        ST_INIT_WAIT,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD
    } state_t;

    // Upper data bits carry no meaning for this device.
    logic unused_ok;
    assign unused_ok = ^dbus_in[11:9];

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    logic       wrm_prev;
    logic       wr_event;
    logic       push_req;
    logic [8:0] push_entry;

    // Remember last cycle's strobe so a long wrm yields a single event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrm_prev <= 1'b0;
        end else begin
            wrm_prev <= wrm;
        end
    end

    assign wr_event = wrm & ~wrm_prev & (abus == IO_ADDR);

    // Translate a CPU write into a {rs, byte} transaction, if it is one.
    always_comb begin
        push_req   = 1'b0;
        push_entry = 9'h000;
        if (wr_event) begin
            if (!dbus_in[8]) begin
                push_req = 1'b1;
                if ((dbus_in[7:0] < 8'h20) || (dbus_in[7:0] > 8'h7E)) begin
                    push_entry = {1'b1, 8'h3F};
                end else begin
                    push_entry = {1'b1, dbus_in[7:0]};
                end
            end else if (dbus_in[7]) begin
                push_req   = 1'b1;
                push_entry = {2'b01, dbus_in[6:0]};
            end else if (dbus_in[0]) begin
                push_req   = 1'b1;
                push_entry = 9'h001;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transaction FIFO
    // ------------------------------------------------------------------
    logic [8:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CNTW-1:0] count;
    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            push_ok;
    logic [8:0]      fifo_head;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNTW'(FIFO_DEPTH));
    assign push_ok    = push_req & (~fifo_full | pop);
    assign fifo_head  = fifo_mem[rd_ptr];

    // Pointer/occupancy bookkeeping; a push on a full FIFO survives only
    // when the sequencer frees a slot in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CNTW'(1);
            end else if (pop && !push_ok) begin
                count <= count - CNTW'(1);
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    // ------------------------------------------------------------------
    // Keypad read path
    // ------------------------------------------------------------------
    logic [11:0] key_meta;
    logic [11:0] key_sync;

    // Two-flop synchronizer; idle (all released) keypad reads as all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta <= 12'hFFF;
            key_sync <= 12'hFFF;
        end else begin
            key_meta <= keys_n;
            key_sync <= key_meta;
        end
    end

    assign dbus_oe  = rdm & (abus == IO_ADDR);
    assign dbus_out = dbus_oe ? key_sync : 12'h000;

    // ------------------------------------------------------------------
    // LCD sequencer
    // ------------------------------------------------------------------
    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [1:0]    init_step;
    logic [1:0]    init_step_nx;
    logic          rs_nx;
    logic [7:0]    data_nx;
    logic          e_nx;

    function automatic logic [7:0] init_byte(input logic [1:0] step);
        case (step)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h06;
            default: init_byte = 8'h01;
        endcase
    endfunction

    // State, timer and LCD pins are all registered so lcd_e is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_INIT_WAIT;
            cnt       <= CW'(INIT_WAIT - 1);
            init_step <= 2'd0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
            lcd_e     <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            init_step <= init_step_nx;
            lcd_rs    <= rs_nx;
            lcd_data  <= data_nx;
            lcd_e     <= e_nx;
        end
    end

    // Next-state logic; init_step parks at 3 once the power-up sequence ends,
    // so afterwards every HOLD returns to IDLE.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        init_step_nx = init_step;
        rs_nx        = lcd_rs;
        data_nx      = lcd_data;
        pop          = 1'b0;
        case (state)
            ST_INIT_WAIT: begin
                if (cnt == '0) begin
                    init_step_nx = 2'd0;
                    rs_nx        = 1'b0;
                    data_nx      = init_byte(2'd0);
                    state_nx     = ST_SETUP;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    rs_nx    = fifo_head[8];
                    data_nx  = fifo_head[7:0];
                    state_nx = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_nx   = CW'(E_CYCLES - 1);
                state_nx = ST_PULSE;
            end
            ST_PULSE: begin
                if (cnt == '0) begin
                    if (!lcd_rs && (lcd_data == 8'h01)) begin
                        cnt_nx = CW'(CLEAR_WAIT - 1);
                    end else begin
                        cnt_nx = CW'(CMD_WAIT - 1);
                    end
                    state_nx = ST_HOLD;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    if (init_step != 2'd3) begin
                        init_step_nx = init_step + 2'd1;
                        rs_nx        = 1'b0;
                        data_nx      = init_byte(init_step + 2'd1);
                        state_nx     = ST_SETUP;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: begin
                state_nx = ST_INIT_WAIT;
            end
        endcase
        e_nx = (state_nx == ST_PULSE);
    end

    assign busy = (state != ST_IDLE) | ~fifo_empty;

endmodule

// File: doc/q2_lcd_ctrl.md
Name: q2_lcd_ctrl

Overview:
- Memory-mapped display and keypad controller for the q2 bus at I/O address IO_ADDR.
- Decodes CPU writes (char / set-address / clear) into HD44780-style LCD transactions, buffers them in a FIFO, and sequences LCD power-up init plus per-transaction E-strobe timing.
- Serves CPU reads of IO_ADDR with the synchronized active-low keypad word.
- Sits beside RAM on the abus/dbus/rdm/wrm bus.

Parameters:
- IO_ADDR, 12'hFFF, decoded I/O address.
- FIFO_DEPTH, 8, transaction buffer entries (power of 2).
- INIT_WAIT, 1500000, cycles after reset before the first init command.
- E_CYCLES, 25, cycles lcd_e held high.
- CMD_WAIT, 2000, cycles after E falls for normal command or char.
- CLEAR_WAIT, 80000, cycles after E falls for command 0x01.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- abus  in  12  CPU address bus
- dbus_in  in  12  CPU write data
- wrm  in  1  CPU memory write strobe (level, ≥1 cycle)
- rdm  in  1  CPU memory read strobe
- keys_n  in  12  raw keypad lines, active-low
- dbus_out  out  12  read data for IO_ADDR
- dbus_oe  out  1  drive enable for dbus_out
- lcd_rs  out  1  LCD register select (1 = data)
- lcd_e  out  1  LCD enable strobe
- lcd_data  out  8  LCD data bus
- busy  out  1  init pending, transaction in flight, or FIFO non-empty
- overflow  out  1  sticky: a write was dropped on full FIFO

Behaviour:
- Reset values:
  - lcd_e=0, lcd_rs=0, lcd_data=0, overflow=0, busy=1.
  - FIFO empty, key sync flops = 12'hFFF, FSM=INIT_WAIT.
  - Asserting rst mid-strobe forces lcd_e=0 immediately (async).
- Write decode:
  - Event = cycle where wrm=1, previous-cycle wrm=0, and abus==IO_ADDR. Exactly one event per strobe.
  - dbus_in[8]=0: push {rs=1, byte}. byte=dbus_in[7:0]; if <0x20 or >0x7E, byte=0x3F.
  - dbus_in[8]=1 and dbus_in[7]=1: push {0, 0x80|dbus_in[6:0]} (set address).
  - dbus_in[8]=1, [7]=0, [0]=1: push {0, 0x01} (clear).
  - dbus_in[8]=1, [7]=0, [0]=0: ignored.
- FIFO:
  - 9-bit entries.
  - Push accepted if not full, or if a pop occurs in the same cycle.
  - Otherwise the entry is dropped and overflow sets (cleared only by rst).
  - Writes are accepted during init.
- Read path (combinational):
  - dbus_oe = rdm & (abus==IO_ADDR).
  - dbus_out = keys_n after a 2-flop synchronizer, passed unmodified (active-low).
  - dbus_out=0 when dbus_oe=0.
- FSM states: INIT_WAIT, IDLE, SETUP, PULSE, HOLD.
  - INIT_WAIT: count INIT_WAIT cycles, then load init step 0 and go to SETUP.
  - Init steps, issued before any FIFO entry: 0x38, 0x0C, 0x06, 0x01, all rs=0, each with the normal SETUP/PULSE/HOLD timing.
  - IDLE: if FIFO non-empty, pop, latch rs/data onto lcd_rs/lcd_data, go to SETUP.
  - SETUP: 1 cycle, lcd_e=0, then PULSE.
  - PULSE: lcd_e=1 for exactly E_CYCLES cycles, then HOLD.
  - HOLD: lcd_e=0 for CLEAR_WAIT cycles if {rs,data}=={0,0x01}, else CMD_WAIT cycles. Then the next init step, or IDLE after the last one.
  - lcd_rs/lcd_data hold stable from SETUP through the end of HOLD.
- Pop-to-E latency: pop in IDLE at cycle t, lcd_e rises at t+2.
- busy = (state!=IDLE) | FIFO non-empty.
- Counters are sized for the largest wait and saturate-free (reload per state).

Test Plan (params INIT_WAIT=4, E_CYCLES=2, CMD_WAIT=3, CLEAR_WAIT=6, FIFO_DEPTH=4):
- Release rst -> four E pulses carrying 0x38, 0x0C, 0x06, 0x01 (rs=0), each E high exactly 2 cycles. Gap after 0x01 is 6 cycles, others 3. Then busy=0.
- After init, write 0x041 to 0xFFF -> one pulse, rs=1, data=0x41. Writing 0x041 to 0xFFE -> no pulse. Holding wrm 3 cycles -> exactly one pulse.
- Write 0x007 -> data 0x3F. Write 0x18A -> rs=0, data=0x8A. Write 0x101 -> data 0x01 with 6-cycle hold. Write 0x100 -> no transaction.
- During init, write 6 chars back-to-back -> first 4 emitted in order after init, overflow=1, last 2 never appear.
- rdm=1, abus=0xFFF, keys_n=0xDFF held ≥2 cycles -> dbus_oe=1, dbus_out=0xDFF. abus=0x123 -> dbus_oe=0.
- Assert rst while lcd_e=1 -> lcd_e=0 same cycle, FIFO flushed, init sequence restarts.
